// File: rtl/seg_595_scan_chain_if.sv
// Serial bus toward a daisy-chained 74HC595 pair.
// The master drives shift/latch/data/enable plus the frame marker.
interface seg_595_scan_chain_if;
  logic shcp;
  logic stcp;
  logic ds;
  logic oe;
  logic frame_done;

  modport master (
    output shcp,
    output stcp,
    output ds,
    output oe,
    output frame_done
  );

  modport slave (
    input shcp,
    input stcp,
    input ds,
    input oe,
    input frame_done
  );
endinterface

// File: rtl/seg_595_scan_chain.sv
// Dynamic-scan 7-seg driver serialising {code, one-hot select} to two 595s.
// Optional BRIGHT_PWM_EN macro adds a 4-bit brightness PWM on oe.
module seg_595_scan_chain #(
  parameter int unsigned NUM_DIG      = 6,
  parameter int unsigned SEG_W        = 8,
  parameter int unsigned CNT_SCAN_MAX = 49_999,
  parameter int unsigned SHCP_DIV     = 2,
  parameter logic [SEG_W-1:0] SEG_OFF = {SEG_W{1'b1}}
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NUM_DIG*SEG_W-1:0] seg_data,
  input  logic [NUM_DIG-1:0]       dig_en,
  input  logic [3:0]               bright,
  seg_595_scan_chain_if.master     hc
);

  localparam int unsigned TOTAL = SEG_W + NUM_DIG;
  localparam int unsigned PW =
    (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int unsigned DW =
    (SHCP_DIV > 1) ? $clog2(SHCP_DIV) : 1;
  localparam int unsigned BW = $clog2(TOTAL);
  localparam int unsigned CW =
    (CNT_SCAN_MAX > 0) ? $clog2(CNT_SCAN_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    HOLD
  } state_e;

  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  logic               tick;
  state_e             state_q;
  logic [TOTAL-1:0]   sh_q;
  logic [PW-1:0]      ptr_q;
  logic [DW-1:0]      div_q;
  logic [BW-1:0]      bit_q;
  logic               shcp_q;
  logic               stcp_q;
  logic               fd_q;
  logic               oe_q;
  logic [SEG_W-1:0]   code;
  logic [NUM_DIG-1:0] sel;
  logic [TOTAL-1:0]   frame;
  logic               div_end;

  assign tick  = (cnt_q == CW'(CNT_SCAN_MAX));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  always_comb begin
    code = SEG_OFF;
    if (dig_en[ptr_q])
      code = seg_data[ptr_q*SEG_W +: SEG_W];
    sel = NUM_DIG'(1) << ptr_q;
  end

  assign frame   = {code, sel};
  assign div_end = (div_q == DW'(SHCP_DIV - 1));

  // ds is the shift register MSB, so it only moves on load or shcp fall
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      ptr_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      unique case (state_q)
        IDLE, HOLD: begin
          if (tick) begin
            sh_q    <= frame;
            div_q   <= '0;
            bit_q   <= '0;
            shcp_q  <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!shcp_q) begin
              shcp_q <= 1'b1;
            end else begin
              shcp_q <= 1'b0;
              if (bit_q == BW'(TOTAL - 1)) begin
                stcp_q  <= 1'b1;
                state_q <= LATCH;
              end else begin
                bit_q <= bit_q + 1'b1;
                sh_q  <= {sh_q[TOTAL-2:0], 1'b0};
              end
            end
          end
        end
        LATCH: begin
          if (!div_end) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q   <= '0;
            stcp_q  <= 1'b0;
            state_q <= HOLD;
            if (ptr_q == PW'(NUM_DIG - 1)) begin
              fd_q  <= 1'b1;
              ptr_q <= '0;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BRIGHT_PWM_EN
  logic [3:0] pwm_q;
  logic [3:0] pwm_d;

  assign pwm_d = pwm_q + 4'd1;

  // oe is registered against the counter value it will sit beside
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pwm_q <= 4'd0;
      oe_q  <= 1'b1;
    end else begin
      pwm_q <= pwm_d;
      oe_q  <= !(pwm_d < bright);
    end
  end
`else
  logic unused_bright;
  assign unused_bright = ^bright;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) oe_q <= 1'b1;
    else         oe_q <= 1'b0;
  end
`endif

  assign hc.shcp       = shcp_q;
  assign hc.stcp       = stcp_q;
  assign hc.ds         = sh_q[TOTAL-1];
  assign hc.oe         = oe_q;
  assign hc.frame_done = fd_q;

endmodule

// File: tb/tb_seg_595_scan_chain.sv
// Bench for seg_595_scan_chain: observes the 595 bus at protocol level
// and compares each latched word against a digit-rule model.
module tb_seg_595_scan_chain;

  localparam int ND  = 6;
  localparam int SCN = 49;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [47:0] seg_data = '0;
  logic [5:0]  dig_en = 6'h3F;
  logic [3:0]  bright = 4'd0;

  seg_595_scan_chain_if hc ();

  seg_595_scan_chain #(
    .NUM_DIG(ND),
    .SEG_W(8),
    .CNT_SCAN_MAX(SCN),
    .SHCP_DIV(1),
    .SEG_OFF(8'hFF)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .seg_data(seg_data),
    .dig_en(dig_en),
    .bright(bright),
    .hc(hc.master)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge sys_clk) cyc++;

  typedef struct {
    logic [13:0] word;
    int          nbits;
    int          first_rise;
    int          st_rise;
    int          width;
    logic        fd;
    int          idx;
  } frm_t;

  frm_t        frames[$];
  logic [13:0] acc;
  int          nb, first_rise, st_rise, st_w, mon_cnt, fd_cnt;
  logic        p_shcp, p_stcp;

  always @(negedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      acc = '0; nb = 0; st_w = 0; mon_cnt = 0;
      p_shcp = 1'b0; p_stcp = 1'b0;
    end else begin
      if (hc.frame_done === 1'b1) fd_cnt++;
      if (hc.shcp && !p_shcp) begin
        if (nb == 0) first_rise = cyc;
        acc = {acc[12:0], hc.ds};
        nb++;
      end
      if (hc.stcp) st_w++;
      if (hc.stcp && !p_stcp) st_rise = cyc;
      if (!hc.stcp && p_stcp) begin
        frames.push_back('{acc, nb, first_rise, st_rise, st_w,
                           hc.frame_done, mon_cnt});
        mon_cnt++;
        nb = 0; st_w = 0; acc = '0;
      end
      p_shcp = hc.shcp;
      p_stcp = hc.stcp;
    end
  end

  // Expected 14-bit word for digit p, built from the display rules
  function automatic logic [13:0] exp_word(logic [47:0] seg,
                                           logic [5:0] en, int p);
    int code;
    code = en[p] ? int'((seg >> (8 * p)) & 48'hFF) : 'hFF;
    return 14'((code << 6) | (1 << p));
  endfunction

  task automatic test_reset();
    #1;
    total += 5;
    if (hc.shcp !== 1'b0) begin bad++; $display("FAIL rst_shcp got=%b exp=0", hc.shcp); end
    if (hc.stcp !== 1'b0) begin bad++; $display("FAIL rst_stcp got=%b exp=0", hc.stcp); end
    if (hc.ds !== 1'b0) begin bad++; $display("FAIL rst_ds got=%b exp=0", hc.ds); end
    if (hc.oe !== 1'b1) begin bad++; $display("FAIL rst_oe got=%b exp=1", hc.oe); end
    if (hc.frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd got=%b exp=0", hc.frame_done); end
  endtask

  task automatic test_first_frame();
    int rel, n;
    seg_data = {$urandom, $urandom};
    seg_data[7:0] = 8'hC0;
    dig_en = 6'h3F;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    rel = cyc;
    frames.delete();
    n = 0;
    while (frames.size() < 1 && n < 200) begin @(posedge sys_clk); n++; end
    #1;
    total++;
    if (frames.size() < 1) begin
      bad++; $display("FAIL first_timeout got=none exp=frame");
    end else begin
      total += 5;
      if (frames[0].word !== 14'h3001) begin bad++; $display("FAIL first_word got=%h exp=3001", frames[0].word); end
      if (frames[0].nbits != 14) begin bad++; $display("FAIL first_nbits got=%0d exp=14", frames[0].nbits); end
      if (frames[0].width != 1) begin bad++; $display("FAIL first_stcp_w got=%0d exp=1", frames[0].width); end
      if (frames[0].first_rise - rel != SCN + 2) begin
        bad++; $display("FAIL first_tick got=%0d exp=%0d", frames[0].first_rise - rel, SCN + 2);
      end
      if (frames[0].st_rise - rel != SCN + 29) begin
        bad++; $display("FAIL first_latch got=%0d exp=%0d", frames[0].st_rise - rel, SCN + 29);
      end
    end
  endtask

  task automatic test_free_run();
    int ndone;
    @(posedge sys_clk); #1;
    frames.delete();
    fd_cnt = 0;
    repeat (600) @(posedge sys_clk);
    #1;
    total++;
    if (frames.size() < 11) begin bad++; $display("FAIL run_count got=%0d exp>=11", frames.size()); end
    ndone = 0;
    for (int i = 0; i < frames.size(); i++) begin
      logic [13:0] e;
      e = exp_word(seg_data, dig_en, frames[i].idx % ND);
      total += 3;
      if (frames[i].word !== e) begin bad++; $display("FAIL run_word[%0d] got=%h exp=%h", i, frames[i].word, e); end
      if (frames[i].width != 1) begin bad++; $display("FAIL run_stcp_w[%0d] got=%0d exp=1", i, frames[i].width); end
      if (frames[i].fd !== (frames[i].idx % ND == ND - 1)) begin
        bad++; $display("FAIL run_fd[%0d] got=%b idx=%0d", i, frames[i].fd, frames[i].idx);
      end
      if (frames[i].idx % ND == ND - 1) ndone++;
      if (i > 0) begin
        total++;
        if (frames[i].st_rise - frames[i-1].st_rise != SCN + 1) begin
          bad++; $display("FAIL run_period[%0d] got=%0d exp=%0d", i, frames[i].st_rise - frames[i-1].st_rise, SCN + 1);
        end
      end
    end
    total++;
    if (fd_cnt != ndone) begin bad++; $display("FAIL run_fd_pulses got=%0d exp=%0d", fd_cnt, ndone); end
  endtask

  task automatic test_blank();
    int m, n;
    m = mon_cnt;
    n = 0;
    while (mon_cnt == m && n < 200) begin @(posedge sys_clk); #1; n++; end
    seg_data = {$urandom, $urandom};
    seg_data[23:16] = 8'hA4;
    dig_en = 6'b111011;
    frames.delete();
    n = 0;
    while (frames.size() < ND && n < 600) begin @(posedge sys_clk); n++; end
    #1;
    total++;
    if (frames.size() < ND) begin bad++; $display("FAIL blank_timeout got=%0d exp=%0d", frames.size(), ND); end
    for (int i = 0; i < frames.size(); i++) begin
      logic [13:0] e;
      e = exp_word(seg_data, dig_en, frames[i].idx % ND);
      if (frames[i].idx % ND == 2) begin
        total++;
        if (frames[i].word !== 14'h3FC4) begin bad++; $display("FAIL blank_dig2 got=%h exp=3fc4", frames[i].word); end
      end
      total++;
      if (frames[i].word !== e) begin bad++; $display("FAIL blank_word[%0d] got=%h exp=%h", i, frames[i].word, e); end
    end
  endtask

  task automatic test_hold_inputs();
    int m, n, seen;
    dig_en = 6'h3F;
    m = mon_cnt;
    n = 0;
    while (mon_cnt == m && n < 200) begin @(posedge sys_clk); #1; n++; end
    seg_data = {$urandom, $urandom};
    seg_data[15:8] = 8'hF9;
    frames.delete();
    n = 0;
    while (!(mon_cnt % ND == 1 && nb == 1) && n < 600) begin @(posedge sys_clk); #1; n++; end
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    seg_data[15:8] = 8'h99;
    n = 0;
    seen = 0;
    while (seen < 2 && n < 800) begin
      @(posedge sys_clk); #1; n++;
      seen = 0;
      foreach (frames[i]) if (frames[i].idx % ND == 1) seen++;
    end
    total++;
    if (seen < 2) begin bad++; $display("FAIL hold_timeout got=%0d exp=2", seen); end
    seen = 0;
    foreach (frames[i]) begin
      if (frames[i].idx % ND == 1 && seen < 2) begin
        logic [13:0] e;
        e = (seen == 0) ? 14'h3E42 : 14'h2642;
        total++;
        if (frames[i].word !== e) begin bad++; $display("FAIL hold_dig1_%0d got=%h exp=%h", seen, frames[i].word, e); end
        seen++;
      end
    end
  endtask

  task automatic test_async_reset();
    int n, rel;
    n = 0;
    while (nb != 4 && n < 200) begin @(posedge sys_clk); #1; n++; end
    total++;
    if (nb != 4) begin bad++; $display("FAIL arst_wait got=%0d exp=4", nb); end
    @(posedge sys_clk);
    #2;
    sys_rst = 1'b1;
    #1;
    total += 4;
    if (hc.shcp !== 1'b0) begin bad++; $display("FAIL arst_shcp got=%b exp=0", hc.shcp); end
    if (hc.stcp !== 1'b0) begin bad++; $display("FAIL arst_stcp got=%b exp=0", hc.stcp); end
    if (hc.ds !== 1'b0) begin bad++; $display("FAIL arst_ds got=%b exp=0", hc.ds); end
    if (hc.oe !== 1'b1) begin bad++; $display("FAIL arst_oe got=%b exp=1", hc.oe); end
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    rel = cyc;
    frames.delete();
    n = 0;
    while (frames.size() < 1 && n < 200) begin @(posedge sys_clk); n++; end
    #1;
    total++;
    if (frames.size() < 1) begin
      bad++; $display("FAIL arst_timeout got=none exp=frame");
    end else begin
      logic [13:0] e;
      e = exp_word(seg_data, dig_en, 0);
      total += 2;
      if (frames[0].word !== e) begin bad++; $display("FAIL arst_word got=%h exp=%h", frames[0].word, e); end
      if (frames[0].first_rise - rel != SCN + 2) begin
        bad++; $display("FAIL arst_tick got=%0d exp=%0d", frames[0].first_rise - rel, SCN + 2);
      end
    end
  endtask

`ifdef BRIGHT_PWM_EN
  task automatic test_pwm();
    logic [3:0] lv[3];
    int lows;
    lv[0] = 4'd4; lv[1] = 4'd0; lv[2] = 4'd15;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      bright = lv[k];
      repeat (3) @(negedge sys_clk);
      lows = 0;
      repeat (16) begin @(negedge sys_clk); if (hc.oe === 1'b0) lows++; end
      total++;
      if (lows != int'(lv[k])) begin bad++; $display("FAIL pwm_%0d got=%0d exp=%0d", lv[k], lows, lv[k]); end
    end
  endtask
`else
  task automatic test_oe_on();
    int highs;
    highs = 0;
    repeat (64) begin @(negedge sys_clk); if (hc.oe !== 1'b0) highs++; end
    total++;
    if (highs != 0) begin bad++; $display("FAIL oe_on got=%0d exp=0", highs); end
  endtask
`endif

  initial begin
    fd_cnt = 0;
    repeat (3) @(negedge sys_clk);
    test_reset();
    test_first_frame();
    test_free_run();
    test_blank();
    test_hold_inputs();
    test_async_reset();
`ifdef BRIGHT_PWM_EN
    test_pwm();
`else
    test_oe_on();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
